mem_arbiter: RTL

//  Shares one single-ported, fixed-latency RAM between the fetch stage (instruction

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port RAM between instruction fetch and data access.
// Data wins ties, but never twice in a row while a fetch is waiting.
module mem_arbiter #(
    parameter int RAM_LAT = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(RAM_LAT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_d;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_ren;
    logic        r_wen;

    logic w_dreq;
    logic w_gnt_d;
    logic w_gnt_i;
    logic w_busy;
    logic w_done;

    assign w_dreq  = dREN | dWEN;
    assign w_gnt_d = w_dreq & ~(iREN & r_last_d);
    assign w_gnt_i = iREN & ~w_gnt_d;
    assign w_busy  = (r_state != IDLE);
    assign w_done  = w_busy && (r_cnt == LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_last_d <= 1'b0;
            r_addr   <= 32'd0;
            r_store  <= 32'd0;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_gnt_d) begin
                        r_state  <= DACC;
                        r_addr   <= daddr;
                        r_store  <= dWEN ? dstore : 32'd0;
                        r_ren    <= dREN;
                        r_wen    <= dWEN;
                        r_last_d <= 1'b1;
                    end else if (w_gnt_i) begin
                        r_state  <= IACC;
                        r_addr   <= iaddr;
                        r_store  <= 32'd0;
                        r_ren    <= 1'b1;
                        r_wen    <= 1'b0;
                        r_last_d <= 1'b0;
                    end
                end
                IACC, DACC: begin
                    // completion returns to IDLE for the mandatory turnaround cycle
                    if (w_done) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign ramREN   = w_busy & r_ren;
    assign ramWEN   = w_busy & r_wen;
    assign ramaddr  = w_busy ? r_addr : 32'd0;
    assign ramstore = w_busy ? r_store : 32'd0;

    assign iwait = ~(w_done && (r_state == IACC));
    assign dwait = ~(w_done && (r_state == DACC));
    assign iload = (w_done && (r_state == IACC)) ? ramload : 32'd0;
    assign dload = (w_done && (r_state == DACC) && r_ren) ? ramload : 32'd0;

endmodule
